// File: rtl/sha3_sponge_ctrl.sv
// -----------------------------------------------------------------------------
// sha3_sponge_ctrl
// Sequencer for a SHA3 sponge datapath. It carries no data. It steers the
// state register and round logic through four phases:
//   absorb  - gives the rate word index for XOR of the incoming stream word
//   pad     - gives the pad10*1 strobes (0x06 on the first pad word, 0x80 on
//             the last rate word)
//   permute - gives NUM_ROUNDS consecutive round enables and the round index
//   squeeze - runs the digest-word output handshake
// Ports:
//   ACLK, ARESET          clock and synchronous active-high reset
//   s_tvalid/s_tlast      message stream in; s_tready accepts a word
//   state_clr             1-cycle pulse that clears the sponge state
//   absorb_en             XOR s_tdata into rate word word_idx
//   pad_en/pad_first/
//   pad_last              padding strobes for rate word word_idx
//   word_idx              rate word index for absorb/pad
//   round_en/round_idx    Keccak round enable and round constant index
//   m_tvalid/m_tlast      digest stream out; m_tready comes from the sink
//   out_idx               digest word index
//   busy/done             busy while not idle; done pulses after the last digest beat
// -----------------------------------------------------------------------------
module sha3_sponge_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int RATE_WORDS = 68,
  parameter int NUM_ROUNDS = 24,
  parameter int OUT_WORDS  = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          s_tvalid,
  input  logic                          s_tlast,
  output logic                          s_tready,
  output logic                          state_clr,
  output logic                          absorb_en,
  output logic                          pad_en,
  output logic                          pad_first,
  output logic                          pad_last,
  output logic [$clog2(RATE_WORDS)-1:0] word_idx,
  output logic                          round_en,
  output logic [4:0]                    round_idx,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic [$clog2(OUT_WORDS)-1:0]  out_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int WIDX_W = $clog2(RATE_WORDS);
  localparam int OIDX_W = $clog2(OUT_WORDS);
  localparam logic [WIDX_W-1:0] RATE_LAST  = WIDX_W'(RATE_WORDS - 1);
  localparam logic [4:0]        ROUND_LAST = 5'(NUM_ROUNDS - 1);
  localparam logic [OIDX_W-1:0] OUT_LAST   = OIDX_W'(OUT_WORDS - 1);

  // The digest must fit in one rate block because there is no re-permute.
  // The datapath also expects whole 16-bit words.
  if (RATE_WORDS < OUT_WORDS || DATA_WIDTH != 16) begin : g_cfg_err
    $error("sha3_sponge_ctrl: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ABSORB  = 3'd1,
    ST_PAD     = 3'd2,
    ST_PERMUTE = 3'd3,
    ST_SQUEEZE = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [WIDX_W-1:0]   word_idx_nxt;
  logic [4:0]          round_idx_nxt;
  logic [OIDX_W-1:0]   out_idx_nxt;
  logic                pad_pending, pad_pending_nxt;  // message ended on a full block; pad block follows
  logic                last_block, last_block_nxt;    // the padded block is absorbed; squeeze after permute
  logic                pad_first_q, pad_first_nxt;    // the next PAD cycle is the first one
  logic                done_q, done_nxt;

  // State and counter registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= ST_IDLE;
      word_idx    <= '0;
      round_idx   <= 5'd0;
      out_idx     <= '0;
      pad_pending <= 1'b0;
      last_block  <= 1'b0;
      pad_first_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      word_idx    <= word_idx_nxt;
      round_idx   <= round_idx_nxt;
      out_idx     <= out_idx_nxt;
      pad_pending <= pad_pending_nxt;
      last_block  <= last_block_nxt;
      pad_first_q <= pad_first_nxt;
      done_q      <= done_nxt;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_nxt       = state;
    word_idx_nxt    = word_idx;
    round_idx_nxt   = round_idx;
    out_idx_nxt     = out_idx;
    pad_pending_nxt = pad_pending;
    last_block_nxt  = last_block;
    pad_first_nxt   = 1'b0;
    done_nxt        = 1'b0;
    case (state)
      ST_IDLE: begin
        pad_pending_nxt = 1'b0;
        last_block_nxt  = 1'b0;
        if (s_tvalid) begin
          state_nxt = ST_ABSORB;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ABSORB: begin
        if (s_tvalid) begin
          if (word_idx == RATE_LAST) begin
            // A full block ends a message: the pad block is still owed after the permute.
            word_idx_nxt    = '0;
            pad_pending_nxt = s_tlast;
            state_nxt       = ST_PERMUTE;
          end else begin
            word_idx_nxt = word_idx + 1'b1;
            if (s_tlast) begin
              pad_first_nxt = 1'b1;
              state_nxt     = ST_PAD;
            end else begin
              state_nxt = ST_ABSORB;
            end
          end
        end else begin
          state_nxt = ST_ABSORB;
        end
      end
      ST_PAD: begin
        if (word_idx == RATE_LAST) begin
          word_idx_nxt   = '0;
          last_block_nxt = 1'b1;
          state_nxt      = ST_PERMUTE;
        end else begin
          word_idx_nxt = word_idx + 1'b1;
          state_nxt    = ST_PAD;
        end
      end
      ST_PERMUTE: begin
        if (round_idx == ROUND_LAST) begin
          round_idx_nxt = 5'd0;
          if (pad_pending) begin
            pad_pending_nxt = 1'b0;
            pad_first_nxt   = 1'b1;
            state_nxt       = ST_PAD;
          end else if (last_block) begin
            state_nxt = ST_SQUEEZE;
          end else begin
            state_nxt = ST_ABSORB;
          end
        end else begin
          round_idx_nxt = round_idx + 5'd1;
          state_nxt     = ST_PERMUTE;
        end
      end
      ST_SQUEEZE: begin
        if (m_tready) begin
          if (out_idx == OUT_LAST) begin
            out_idx_nxt    = '0;
            last_block_nxt = 1'b0;
            done_nxt       = 1'b1;
            state_nxt      = ST_IDLE;
          end else begin
            out_idx_nxt = out_idx + 1'b1;
            state_nxt   = ST_SQUEEZE;
          end
        end else begin
          state_nxt = ST_SQUEEZE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state
  always_comb begin
    s_tready  = (state == ST_ABSORB);
    absorb_en = s_tvalid & s_tready;
    // The reset gate keeps state_clr quiet while ARESET is held with s_tvalid high.
    state_clr = (state == ST_IDLE) & s_tvalid & ~ARESET;
    pad_en    = (state == ST_PAD);
    pad_first = (state == ST_PAD) & pad_first_q;
    pad_last  = (state == ST_PAD) & (word_idx == RATE_LAST);
    round_en  = (state == ST_PERMUTE);
    m_tvalid  = (state == ST_SQUEEZE);
    m_tlast   = (state == ST_SQUEEZE) & (out_idx == OUT_LAST);
    busy      = (state != ST_IDLE);
    done      = done_q;
  end

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sha3_sponge_ctrl
// Directed bench for the SHA3 sponge sequencer. A negedge monitor counts the
// strobes and checks the index sequences. Each test then compares the event
// totals with hand-computed values.
// -----------------------------------------------------------------------------
module tb_sha3_sponge_ctrl;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       s_tvalid, s_tlast, s_tready;
  logic       state_clr, absorb_en, pad_en, pad_first, pad_last;
  logic [6:0] word_idx;
  logic       round_en;
  logic [4:0] round_idx;
  logic       m_tvalid, m_tlast, m_tready;
  logic [3:0] out_idx;
  logic       busy, done;

  int n_checks = 0;
  int n_errors = 0;

  int cnt_clr, cnt_abs, cnt_pad, cnt_pf, cnt_pl, cnt_pfl, cnt_round, cnt_beat, cnt_done;
  int pf_idx, pl_idx, n_perm;
  int perm_at [4];

  sha3_sponge_ctrl dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .state_clr (state_clr),
    .absorb_en (absorb_en),
    .pad_en    (pad_en),
    .pad_first (pad_first),
    .pad_last  (pad_last),
    .word_idx  (word_idx),
    .round_en  (round_en),
    .round_idx (round_idx),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cnt_clr = 0; cnt_abs = 0; cnt_pad = 0; cnt_pf = 0; cnt_pl = 0; cnt_pfl = 0;
    cnt_round = 0; cnt_beat = 0; cnt_done = 0; pf_idx = -1; pl_idx = -1; n_perm = 0;
    for (int k = 0; k < 4; k++) perm_at[k] = -1;
  endtask

  // Monitor: counts strobes and checks the index sequences every cycle
  always @(negedge ACLK) begin
    check("onehot", 32'($countones({absorb_en, pad_en, round_en, m_tvalid}) <= 1), 32'd1);
    if (!s_tvalid) check("abs_gate", 32'(absorb_en), 32'd0);
    if (state_clr) cnt_clr++;
    if (absorb_en) begin
      check("abs_idx", 32'(word_idx), cnt_abs % 68);
      cnt_abs++;
    end
    if (pad_en) begin
      cnt_pad++;
      if (pad_first) begin cnt_pf++; pf_idx = int'(word_idx); end
      if (pad_last)  begin cnt_pl++; pl_idx = int'(word_idx); end
      if (pad_first && pad_last) cnt_pfl++;
    end
    if (round_en) begin
      check("round_idx", 32'(round_idx), cnt_round % 24);
      if (round_idx == 5'd0 && n_perm < 4) begin
        perm_at[n_perm] = cnt_abs;
        n_perm++;
      end
      cnt_round++;
    end
    if (m_tvalid && m_tready) begin
      check("out_idx", 32'(out_idx), cnt_beat % 16);
      check("m_tlast", 32'(m_tlast), 32'((cnt_beat % 16) == 15));
      cnt_beat++;
    end
    if (done) cnt_done++;
  end

  task automatic send_msg(input int n, input bit gap);
    bit acc;
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tlast  = (i == n - 1);
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge ACLK);
        acc = s_tready;
        @(posedge ACLK); #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      if (!acc) begin
        check("tready_timeout", 32'd0, 32'd1);
        return;
      end
      if (gap) begin
        @(posedge ACLK); #1;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < budget && !seen; t++) begin
      @(posedge ACLK); #1;
      seen = done;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    repeat (3) begin
      @(posedge ACLK); #1;
    end
  endtask

  task automatic expect_run(input int e_abs, input int e_pad, input int e_pf, input int e_pl,
                            input int e_rounds, input int e_pfl);
    check("clr_cnt",   cnt_clr,   32'd1);
    check("abs_cnt",   cnt_abs,   e_abs);
    check("pad_cnt",   cnt_pad,   e_pad);
    check("pf_cnt",    cnt_pf,    32'd1);
    check("pl_cnt",    cnt_pl,    32'd1);
    check("pf_idx",    pf_idx,    e_pf);
    check("pl_idx",    pl_idx,    e_pl);
    check("pfl_cnt",   cnt_pfl,   e_pfl);
    check("round_cnt", cnt_round, e_rounds);
    check("beat_cnt",  cnt_beat,  32'd16);
    check("done_cnt",  cnt_done,  32'd1);
    check("busy_end",  32'(busy), 32'd0);
  endtask

  function automatic logic [26:0] all_outs();
    return {s_tready, state_clr, absorb_en, pad_en, pad_first, pad_last, word_idx,
            round_en, round_idx, m_tvalid, m_tlast, out_idx, busy, done};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit hit;
    clear_stats();
    ARESET = 1'b1; s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) begin
      @(posedge ACLK); #1;
    end
    check("reset_outs", 32'(all_outs()), 32'd0);
    s_tvalid = 1'b0;
    ARESET   = 1'b0;
    @(posedge ACLK); #1;
    check("idle_outs", 32'(all_outs()), 32'd0);

    // 1: short message, padding starts mid-block
    clear_stats();
    send_msg(3, 1'b0);
    wait_done(400);
    expect_run(3, 65, 3, 67, 24, 0);

    // 2: message fills the block exactly, pad block follows a permute
    clear_stats();
    send_msg(68, 1'b0);
    wait_done(600);
    expect_run(68, 68, 0, 67, 48, 0);
    check("t2_perm0", perm_at[0], 32'd68);
    check("t2_perm1", perm_at[1], 32'd68);

    // 3: one word left for padding, pad_first and pad_last coincide
    clear_stats();
    send_msg(67, 1'b0);
    wait_done(400);
    expect_run(67, 1, 67, 67, 24, 1);

    // 4: multi-block message with s_tvalid toggling
    clear_stats();
    send_msg(150, 1'b1);
    wait_done(600);
    expect_run(150, 54, 14, 67, 72, 0);
    check("t4_perm0", perm_at[0], 32'd68);
    check("t4_perm1", perm_at[1], 32'd136);
    check("t4_perm2", perm_at[2], 32'd150);

    // 5: sink back-pressure at out_idx 7
    clear_stats();
    send_msg(3, 1'b0);
    hit = 1'b0;
    for (int t = 0; t < 300 && !hit; t++) begin
      @(posedge ACLK); #1;
      hit = m_tvalid && (out_idx == 4'd7);
    end
    check("t5_reach7", 32'(hit), 32'd1);
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge ACLK); #1;
      check("t5_hold_v", 32'(m_tvalid), 32'd1);
      check("t5_hold_i", 32'(out_idx), 32'd7);
    end
    m_tready = 1'b1;
    wait_done(100);
    expect_run(3, 65, 3, 67, 24, 0);

    // 6: reset during round 10 aborts the hash
    clear_stats();
    send_msg(3, 1'b0);
    hit = 1'b0;
    for (int t = 0; t < 300 && !hit; t++) begin
      @(posedge ACLK); #1;
      hit = round_en && (round_idx == 5'd10);
    end
    check("t6_reach10", 32'(hit), 32'd1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check("t6_outs", 32'(all_outs()), 32'd0);
    ARESET = 1'b0;
    repeat (40) begin
      @(posedge ACLK); #1;
    end
    check("t6_rounds", cnt_round, 32'd11);
    check("t6_done",   cnt_done,  32'd0);
    check("t6_beats",  cnt_beat,  32'd0);
    check("t6_busy",   32'(busy), 32'd0);

    clear_stats();
    send_msg(3, 1'b0);
    wait_done(400);
    expect_run(3, 65, 3, 67, 24, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
